// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter sharing one combinational FPU between two requesters.
// Latency: accept to rsp_valid is LATENCY+1 cycles for a legal rounding mode, 1 cycle for an illegal one.
// Backpressure: one operation in flight; req_ready only in IDLE, and a response holds until rsp_ready[grantee].
//
// Ports: clk/rst (synchronous, active-high); req_valid/req_ready plus the packed per-requester
// operands req_a/b/c and req_frm; fpu_a/b/c/rm go to the shared FPU, and fpu_o/fpu_flags
// come back from it; rsp_valid/rsp_ready/rsp_o/rsp_flags carry the response; fflags_clr/fflags
// give sticky exception flags.
// Optional feature: define STICKY_FLAGS_EN to build the sticky flag register. Without it,
// fflags is tied to 0 and fflags_clr is ignored.
module fpu_arbiter #(
    parameter int LATENCY = 2          // legal range 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [63:0] req_c,
    input  logic [5:0]  req_frm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [31:0] fpu_c,
    output logic [4:0]  fpu_rm,
    input  logic [31:0] fpu_o,
    input  logic [4:0]  fpu_flags,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_o,
    output logic [4:0]  rsp_flags,
    input  logic        fflags_clr,
    output logic [4:0]  fflags
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_q, last_d;     // requester granted most recently
    logic        id_q, id_d;         // requester owning the op in flight
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [4:0]  rm_q, rm_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  flg_q, flg_d;

    logic        grant;
    logic [31:0] sel_a, sel_b, sel_c;
    logic [2:0]  sel_frm;
    logic [4:0]  rm_dec;
    logic        frm_illegal;
    logic        accept;
    logic        rsp_hs;

    // With both requesting, alternate away from the last grantee; with one, take it.
    // With none the value is irrelevant because req_ready is masked by req_valid.
    assign grant   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    assign sel_a   = grant ? req_a[63:32] : req_a[31:0];
    assign sel_b   = grant ? req_b[63:32] : req_b[31:0];
    assign sel_c   = grant ? req_c[63:32] : req_c[31:0];
    assign sel_frm = grant ? req_frm[5:3] : req_frm[2:0];

    // One-hot rounding mode ordered {RTZ,RTN,RTP,RNA,RNE}.
    always_comb begin
        rm_dec      = 5'b00000;
        frm_illegal = 1'b0;
        case (sel_frm)
            3'd0:    rm_dec = 5'b00001;
            3'd1:    rm_dec = 5'b10000;
            3'd2:    rm_dec = 5'b01000;
            3'd3:    rm_dec = 5'b00100;
            3'd4:    rm_dec = 5'b00010;
            default: frm_illegal = 1'b1;
        endcase
    end

    assign req_ready = (state_q == IDLE && !rst) ? ((grant ? 2'b10 : 2'b01) & req_valid) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign rsp_hs    = (state_q == RESP) && rsp_ready[id_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        rm_d    = rm_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d   = grant;
                    last_d = grant;
                    a_d    = sel_a;
                    b_d    = sel_b;
                    c_d    = sel_c;
                    rm_d   = rm_dec;
                    if (frm_illegal) begin
                        // Canonical quiet NaN with invalid-operation; the FPU is never driven.
                        res_d   = 32'h7fc0_0000;
                        flg_d   = 5'b10000;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 2'(LATENCY - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    res_d   = fpu_o;
                    flg_d   = fpu_flags;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 1'b1;     // requester 0 wins the first tie
            id_q    <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            rm_q    <= 5'b00001;
            res_q   <= 32'd0;
            flg_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            rm_q    <= rm_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    // The FPU sees the operands only while BUSY, and neutral values at all other times.
    assign fpu_a  = (state_q == BUSY) ? a_q  : 32'd0;
    assign fpu_b  = (state_q == BUSY) ? b_q  : 32'd0;
    assign fpu_c  = (state_q == BUSY) ? c_q  : 32'd0;
    assign fpu_rm = (state_q == BUSY) ? rm_q : 5'b00001;

    assign rsp_valid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_o     = (state_q == RESP) ? res_q : 32'd0;
    assign rsp_flags = (state_q == RESP) ? flg_q : 5'd0;

`ifdef STICKY_FLAGS_EN
    logic [4:0] fflags_q, fflags_d;

    // A clear and a handshake in the same cycle both apply: the new flags survive the clear.
    assign fflags_d = (fflags_clr ? 5'd0 : fflags_q) | (rsp_hs ? flg_q : 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q <= 5'd0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
    assign fflags            = 5'd0;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed scoreboard bench for fpu_arbiter driving a combinational fp32 FPU model.
// Latency: expected responses are queued at issue and popped when the DUT first presents rsp_valid.
// Backpressure: rsp_ready is normally high and is dropped by the hold and sticky-clear sequences.
module tb_fpu_arbiter;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b, req_c;
    logic [5:0]  req_frm;
    logic [31:0] fpu_a, fpu_b, fpu_c, fpu_o;
    logic [4:0]  fpu_rm, fpu_flags;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_o;
    logic [4:0]  rsp_flags;
    logic        fflags_clr;
    logic [4:0]  fflags;

    fpu_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_frm(req_frm),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_rm(fpu_rm),
        .fpu_o(fpu_o), .fpu_flags(fpu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_o(rsp_o), .rsp_flags(rsp_flags),
        .fflags_clr(fflags_clr), .fflags(fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FPU model: a*b+c on normal fp32 values. A subnormal/zero c counts as zero, and its
    // low five bits are returned as the exception flags so a test can choose them.
    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    assign fpu_o     = r2f(f2r(fpu_a) * f2r(fpu_b) + f2r(fpu_c));
    assign fpu_flags = (fpu_c[30:23] == 8'd0) ? fpu_c[4:0] : 5'd0;

    typedef struct {
        logic [31:0] a, b, c;
        logic [2:0]  frm;
        logic [31:0] res;    // hand-computed a*b+c
        logic [4:0]  fl;     // flags the model reports for this op
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] o;
        logic [4:0]  fl;
        logic [4:0]  rm;
        bit          legal;
    } exp_t;

    op_t  pend0[$], pend1[$];
    exp_t exp_q[$];
    int   acc_q[$];
    op_t  tie_ops[8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] rm_of(input logic [2:0] frm);
        case (frm)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b10000;
            3'd2:    return 5'b01000;
            3'd3:    return 5'b00100;
            3'd4:    return 5'b00010;
            default: return 5'b00001;
        endcase
    endfunction

    task automatic issue(input int id, input op_t op);
        exp_t e;
        e.id    = id;
        e.legal = (op.frm <= 3'd4);
        e.o     = e.legal ? op.res : 32'h7fc0_0000;
        e.fl    = e.legal ? op.fl : 5'b10000;
        e.rm    = rm_of(op.frm);
        exp_q.push_back(e);
        if (id == 0) pend0.push_back(op);
        else         pend1.push_back(op);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0 || rsp_valid != 2'b00) && g < 300) begin
            @(posedge clk); #2;
            g++;
        end
        if (g >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses still outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic wait_rsp();
        int g = 0;
        @(negedge clk);
        while (rsp_valid == 2'b00 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid stayed 00, required a response");
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        pend0.delete();
        pend1.delete();
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Driver: present the head of each requester queue; pop on accept.
    initial begin
        logic [1:0] acc;
        req_valid = 2'b00;
        req_a = '0; req_b = '0; req_c = '0; req_frm = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc = req_valid & req_ready;
                chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
                chk("req_ready_unrequested", {30'd0, req_ready & ~req_valid}, 32'd0);
                if (acc != 2'b00) begin
                    chk("accept_during_rsp", {30'd0, rsp_valid}, 32'd0);
                    acc_q.push_back(cyc);
                    if (acc[0]) pend0.delete(0);
                    else        pend1.delete(0);
                end
            end
            @(posedge clk); #1;
            req_valid = {pend1.size() > 0, pend0.size() > 0};
            if (pend0.size() > 0) begin
                req_a[31:0] = pend0[0].a; req_b[31:0] = pend0[0].b;
                req_c[31:0] = pend0[0].c; req_frm[2:0] = pend0[0].frm;
            end
            if (pend1.size() > 0) begin
                req_a[63:32] = pend1[0].a; req_b[63:32] = pend1[0].b;
                req_c[63:32] = pend1[0].c; req_frm[5:3] = pend1[0].frm;
            end
        end
    end

    // Monitor: compare responses, FPU-port activity, latency and sticky flags.
    initial begin
        int          run;
        logic [4:0]  last_rm;
        bit          prev_vld;
        bit          hs;
        exp_t        cur;
        logic [4:0]  fm;
        run = 0; last_rm = 5'b00001; prev_vld = 0; fm = 5'd0;
        cur = '{id: 0, o: 32'd0, fl: 5'd0, rm: 5'b00001, legal: 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("req_ready_in_reset", {30'd0, req_ready}, 32'd0);
                run = 0; prev_vld = 0; fm = 5'd0;
            end else begin
                chk("fflags", {27'd0, fflags}, {27'd0, fm});
                if (fpu_rm != 5'b00001 || (fpu_a | fpu_b | fpu_c) != 32'd0) begin
                    if (run > 0) chk("fpu_rm_stable", {27'd0, fpu_rm}, {27'd0, last_rm});
                    run++;
                    last_rm = fpu_rm;
                end
                hs = 1'b0;
                if (rsp_valid == 2'b00) begin
                    chk("rsp_o_when_idle", rsp_o, 32'd0);
                    chk("rsp_flags_when_idle", {27'd0, rsp_flags}, 32'd0);
                    prev_vld = 0;
                end else begin
                    if (!prev_vld) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp: rsp_valid %b with no outstanding request", rsp_valid);
                            cur = '{id: 0, o: rsp_o, fl: 5'd0, rm: 5'b00001, legal: 1'b0};
                        end else begin
                            cur = exp_q.pop_front();
                            chk("rsp_valid", {30'd0, rsp_valid}, (cur.id == 1) ? 32'd2 : 32'd1);
                            chk("rsp_o", rsp_o, cur.o);
                            chk("rsp_flags", {27'd0, rsp_flags}, {27'd0, cur.fl});
                            chk("busy_cycles", 32'(run), cur.legal ? 32'(LAT) : 32'd0);
                            if (cur.legal) chk("fpu_rm", {27'd0, last_rm}, {27'd0, cur.rm});
                            if (acc_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL latency: response with no recorded accept");
                            end else begin
                                chk("latency", 32'(cyc - acc_q.pop_front()), cur.legal ? 32'(LAT + 1) : 32'd1);
                            end
                        end
                        run = 0;
                        prev_vld = 1;
                    end else begin
                        chk("rsp_valid_hold", {30'd0, rsp_valid}, (cur.id == 1) ? 32'd2 : 32'd1);
                        chk("rsp_o_hold", rsp_o, cur.o);
                        chk("rsp_flags_hold", {27'd0, rsp_flags}, {27'd0, cur.fl});
                    end
                    if ((rsp_valid & rsp_ready) != 2'b00) begin
                        hs = 1'b1;
                        prev_vld = 0;
                    end
                end
`ifdef STICKY_FLAGS_EN
                fm = (fflags_clr ? 5'd0 : fm) | (hs ? cur.fl : 5'd0);
`endif
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        rsp_ready = 2'b11;
        fflags_clr = 1'b0;
        tie_ops[0] = '{32'h40000000, 32'h40400000, 32'h0,        3'd0, 32'h40c00000, 5'd0}; // 2*3
        tie_ops[1] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 3'd1, 32'h40000000, 5'd0}; // 1*1+1
        tie_ops[2] = '{32'h3f000000, 32'h40800000, 32'h0,        3'd2, 32'h40000000, 5'd0}; // 0.5*4
        tie_ops[3] = '{32'hc0000000, 32'h3fc00000, 32'h0,        3'd3, 32'hc0400000, 5'd0}; // -2*1.5
        tie_ops[4] = '{32'h40400000, 32'h40400000, 32'h3f800000, 3'd4, 32'h41200000, 5'd0}; // 3*3+1
        tie_ops[5] = '{32'h3fc00000, 32'h3fc00000, 32'h0,        3'd0, 32'h40100000, 5'd0}; // 1.5*1.5
        tie_ops[6] = '{32'h40000000, 32'h40000000, 32'hbf800000, 3'd1, 32'h40400000, 5'd0}; // 2*2-1
        tie_ops[7] = '{32'h40800000, 32'h3e800000, 32'h0,        3'd2, 32'h3f800000, 5'd0}; // 4*0.25
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_o", rsp_o, 32'd0);
        chk("reset_rsp_flags", {27'd0, rsp_flags}, 32'd0);
        chk("reset_fflags", {27'd0, fflags}, 32'd0);
        chk("reset_fpu_rm", {27'd0, fpu_rm}, 32'd1);

        // Single legal op, RTP: 1.5*2 = 3.0
        @(posedge clk); #2;
        issue(0, '{32'h3fc00000, 32'h40000000, 32'h0, 3'd3, 32'h40400000, 5'd0});
        wait_drain();

        // Both requesters valid together after reset: grants alternate 0,1,0,1,...
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(0, tie_ops[2*i]);
            issue(1, tie_ops[2*i+1]);
        end
        wait_drain();

        // Illegal rounding modes
        issue(1, '{32'h40000000, 32'h40000000, 32'h0, 3'd5, 32'h0, 5'd0});
        wait_drain();
        issue(0, '{32'h40000000, 32'h40000000, 32'h0, 3'd7, 32'h0, 5'd0});
        wait_drain();

        // Response backpressure
        @(posedge clk); #2;
        rsp_ready = 2'b00;
        issue(0, '{32'h3f800000, 32'h40400000, 32'h0, 3'd1, 32'h40400000, 5'd0});
        wait_rsp();
        issue(1, '{32'h40000000, 32'h40000000, 32'h0, 3'd2, 32'h40800000, 5'd0});
        repeat (5) begin
            @(negedge clk);
            chk("req_ready_while_held", {30'd0, req_ready}, 32'd0);
            chk("rsp_valid_while_held", {30'd0, rsp_valid}, 32'd1);
        end
        @(posedge clk); #2;
        rsp_ready = 2'b10;          // non-grantee ready must not release
        repeat (2) begin
            @(negedge clk);
            chk("nongrantee_ready_ignored", {30'd0, rsp_valid}, 32'd1);
        end
        @(posedge clk); #2;
        rsp_ready = 2'b11;
        wait_drain();

        // Sticky flags
        @(posedge clk); #2 fflags_clr = 1'b1;
        @(posedge clk); #2 fflags_clr = 1'b0;
        issue(0, '{32'h3f800000, 32'h40000000, 32'h1, 3'd4, 32'h40000000, 5'b00001});
        wait_drain();
        issue(1, '{32'h3f800000, 32'h40000000, 32'h4, 3'd0, 32'h40000000, 5'b00100});
        wait_drain();
        @(negedge clk);
`ifdef STICKY_FLAGS_EN
        chk("fflags_accumulate", {27'd0, fflags}, 32'h05);
`else
        chk("fflags_accumulate", {27'd0, fflags}, 32'h00);
`endif
        @(posedge clk); #2;
        rsp_ready = 2'b00;
        issue(0, '{32'h40000000, 32'h3f000000, 32'h8, 3'd2, 32'h3f800000, 5'b01000});
        wait_rsp();
        @(posedge clk); #2;
        fflags_clr = 1'b1;
        rsp_ready  = 2'b11;
        @(posedge clk); #2;
        fflags_clr = 1'b0;
        wait_drain();
        @(negedge clk);
`ifdef STICKY_FLAGS_EN
        chk("fflags_clear_with_handshake", {27'd0, fflags}, 32'h08);
`else
        chk("fflags_clear_with_handshake", {27'd0, fflags}, 32'h00);
`endif

        // Reset in the middle of BUSY aborts the op; the next tie goes to requester 0.
        @(posedge clk); #2;
        issue(0, '{32'h40000000, 32'h40400000, 32'h0, 3'd0, 32'h40c00000, 5'd0});
        begin
            int g = 0;
            while (pend0.size() != 0 && g < 50) begin
                @(posedge clk); #2;
                g++;
            end
            if (g >= 50) begin
                checks++;
                errors++;
                $display("FAIL abort_accept_timeout: request never accepted");
            end
        end
        chk("abort_in_busy", {27'd0, fpu_rm | 5'(fpu_a != 32'd0)}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_fpu_idle", fpu_a, 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("no_rsp_after_abort", {30'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #2;
        issue(0, tie_ops[4]);
        issue(1, tie_ops[5]);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
